int_ctrl: RTL and testbench

Interrupt controller that sits directly upstream of the cpu core and feeds its interrupt inputs. It synchronises four asynchronous external request lines, latches rising edges as pending, applies a software mask, and resolves priority. It then presents one request at a time to the cpu, together with a handler vector, using a req/ack/ret handshake.

---
 rtl/int_pkg.sv | 24 ++
 rtl/sync_edge.sv | 27 ++
 rtl/int_ctrl.sv | 113 +++++++++++
 tb/tb_int_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types, sizes and the vector helper for the interrupt controller.
package int_pkg;

    localparam int N_IRQ = 4;
    localparam int VEC_W = 10;
    localparam int ID_W  = 2;

    localparam logic [VEC_W-1:0] VEC_BASE   = 10'd1000;
    localparam logic [VEC_W-1:0] VEC_STRIDE = 10'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Handler address for a line; wraps silently at VEC_W bits.
    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        logic [VEC_W-1:0] idx;
        idx = VEC_W'(id);
        return VEC_BASE + idx * VEC_STRIDE;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with rising-edge detect on the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, mask, fixed priority,
// and a req/ack/ret handshake towards the cpu core.
module int_ctrl
    import int_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_d,
    output logic [N_IRQ-1:0] mask_q,
    output logic [N_IRQ-1:0] pending_q,
    output logic             int_req,
    output logic [VEC_W-1:0] int_vec,
    output logic [ID_W-1:0]  int_id,
    input  logic             int_ack,
    input  logic             int_ret,
    output logic             in_service
);

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] eligible;
    logic             any;
    logic [ID_W-1:0]  arb_id;
    logic [ID_W-1:0]  id_q;
    logic [ID_W-1:0]  next_id;
    state_t           state;
    state_t           next_state;

    for (genvar k = 0; k < N_IRQ; k++) begin : g_sync
        sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (irq_in[k]),
            .rise  (rise[k])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '1;
        end else if (mask_we) begin
            mask_q <= mask_d;
        end
    end

    // A new edge on the same cycle as the ack-clear keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr) | rise;
        end
    end

    assign eligible = pending_q & mask_q;

    always_comb begin
        any    = 1'b0;
        arb_id = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                any    = 1'b1;
                arb_id = ID_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            id_q  <= '0;
        end else begin
            state <= next_state;
            id_q  <= next_id;
        end
    end

    always_comb begin
        next_state = state;
        next_id    = id_q;
        clr        = '0;
        unique case (state)
            IDLE: begin
                if (any) begin
                    next_state = REQ;
                    next_id    = arb_id;
                end
            end
            REQ: begin
                if (int_ack) begin
                    next_state = SERVICE;
                    clr[id_q]  = 1'b1;
                end
            end
            SERVICE: begin
                if (int_ret) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign int_req    = (state == REQ);
    assign in_service = (state == SERVICE);
    assign int_id     = id_q;
    assign int_vec    = vec_of(id_q);

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_d;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic       int_req;
    logic [9:0] int_vec;
    logic [1:0] int_id;
    logic       int_ack;
    logic       int_ret;
    logic       in_service;

    int total;
    int passed;
    int reqs;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .mask_q     (mask_q),
        .pending_q  (pending_q),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic ret();
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] lines);
        irq_in = lines;
        repeat (3) tick();
        irq_in = 4'b0000;
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        reqs    = 0;
        reset   = 1'b0;
        irq_in  = 4'b0000;
        mask_we = 1'b0;
        mask_d  = 4'b0000;
        int_ack = 1'b0;
        int_ret = 1'b0;
        repeat (3) tick();

        chk("rst_req", 32'(int_req), 0);
        chk("rst_svc", 32'(in_service), 0);
        chk("rst_id", 32'(int_id), 0);
        chk("rst_vec", 32'(int_vec), 1000);
        chk("rst_pend", 32'(pending_q), 0);
        chk("rst_mask", 32'(mask_q), 15);
        reset = 1'b1;
        tick();

        // spurious ack in IDLE
        ack();
        chk("sp_ack_svc", 32'(in_service), 0);

        // single request, line 2
        irq_in = 4'b0100;
        tick();
        chk("t1_e1_req", 32'(int_req), 0);
        tick();
        tick();
        irq_in = 4'b0000;
        chk("t1_e3_pend", 32'(pending_q), 4);
        chk("t1_e3_req", 32'(int_req), 0);
        tick();
        chk("t1_req", 32'(int_req), 1);
        chk("t1_vec", 32'(int_vec), 1008);
        chk("t1_id", 32'(int_id), 2);
        ret();
        chk("sp_ret_req", 32'(int_req), 1);
        ack();
        chk("t1_ack_req", 32'(int_req), 0);
        chk("t1_ack_svc", 32'(in_service), 1);
        chk("t1_ack_pend", 32'(pending_q), 0);
        ret();
        chk("t1_ret_svc", 32'(in_service), 0);
        tick();
        chk("t1_idle_req", 32'(int_req), 0);

        // priority, lines 1 and 3 together
        pulse(4'b1010);
        chk("t2_pend", 32'(pending_q), 10);
        tick();
        chk("t2_req1", 32'(int_req), 1);
        chk("t2_id1", 32'(int_id), 1);
        chk("t2_vec1", 32'(int_vec), 1004);
        ack();
        chk("t2_pend2", 32'(pending_q), 8);
        ret();
        chk("t2_gap", 32'(int_req), 0);
        tick();
        chk("t2_req2", 32'(int_req), 1);
        chk("t2_id2", 32'(int_id), 3);
        chk("t2_vec2", 32'(int_vec), 1012);
        ack();
        ret();

        // mask hides line 0 without clearing it
        mask_we = 1'b1;
        mask_d  = 4'b1110;
        tick();
        mask_we = 1'b0;
        chk("t3_mask", 32'(mask_q), 14);
        pulse(4'b0001);
        repeat (3) tick();
        chk("t3_pend", 32'(pending_q), 1);
        chk("t3_noreq", 32'(int_req), 0);
        mask_we = 1'b1;
        mask_d  = 4'b1111;
        tick();
        mask_we = 1'b0;
        chk("t3_m_req", 32'(int_req), 0);
        tick();
        chk("t3_req", 32'(int_req), 1);
        chk("t3_vec", 32'(int_vec), 1000);
        ack();
        ret();
        tick();

        // edge arriving during service
        pulse(4'b0010);
        tick();
        chk("t4_req1", 32'(int_id), 1);
        ack();
        pulse(4'b0001);
        tick();
        chk("t4_pend", 32'(pending_q), 1);
        chk("t4_noreq", 32'(int_req), 0);
        chk("t4_svc", 32'(in_service), 1);
        ret();
        chk("t4_gap", 32'(int_req), 0);
        tick();
        chk("t4_req2", 32'(int_req), 1);
        chk("t4_id2", 32'(int_id), 0);
        ack();
        ret();
        tick();

        // held level yields one request only
        irq_in = 4'b0001;
        repeat (4) tick();
        chk("t5_req", 32'(int_req), 1);
        chk("t5_id", 32'(int_id), 0);
        ack();
        ret();
        for (int i = 0; i < 44; i++) begin
            tick();
            if (int_req) reqs++;
        end
        irq_in = 4'b0000;
        chk("t5_once", 32'(reqs), 0);
        chk("t5_pend", 32'(pending_q), 0);

        // asynchronous reset while requesting
        mask_we = 1'b1;
        mask_d  = 4'b0111;
        tick();
        mask_we = 1'b0;
        pulse(4'b1100);
        tick();
        chk("t6_req", 32'(int_req), 1);
        chk("t6_pend", 32'(pending_q), 12);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_req", 32'(int_req), 0);
        chk("t6_rst_pend", 32'(pending_q), 0);
        chk("t6_rst_mask", 32'(mask_q), 15);
        chk("t6_rst_vec", 32'(int_vec), 1000);
        tick();
        reset = 1'b1;
        reqs  = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (int_req) reqs++;
        end
        chk("t6_noreq", 32'(reqs), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
